vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares the single-port 8 KB screen RAM between the video scan-out fetch (highest priority,
//  fixed latency) and the Z80 CPU (stallable via n_wait). Sits between the video timing
//  block, the CPU bus decode and the synchronous screen BRAM (1-cycle read latency).
//  Counts CPU contention cycles for debug/timing characterisation.
// PARAMETERS
//  AW   13  address width (8 KB screen + attribute area)
//  DW    8  data width
//  SW   16  width of contention counter (saturating)
// PORTS
//  clk        in   1   system/pixel clock
//  reset      in   1   asynchronous, active-low reset
//  vid_req    in   1   video fetch strobe, one cycle per byte
//  vid_addr   in   AW  video fetch address, valid with vid_req
//  vid_data   out  DW  fetched byte
//  vid_valid  out  1   one-cycle pulse, vid_data valid
//  cpu_req    in   1   CPU access request, level, 4-phase with cpu_ack
//  cpu_we     in   1   1=write, 0=read; stable while cpu_req=1
//  cpu_addr   in   AW  CPU address; stable while cpu_req=1
//  cpu_wdata  in   DW  CPU write data; stable while cpu_req=1
//  cpu_rdata  out  DW  CPU read data, valid while cpu_ack=1 on reads
//  cpu_ack    out  1   completion, level, held until cpu_req sampled low
//  n_wait     out  1   Z80 WAIT, low while cpu_req=1 and cpu_ack=0 (combinational)
//  mem_addr   out  AW  BRAM address (registered)
//  mem_we     out  1   BRAM write enable (registered)
//  mem_wdata  out  DW  BRAM write data (registered)
//  mem_rdata  in   DW  BRAM read data, valid one cycle after address
//  stall_clr  in   1   synchronous clear of stall_cnt
//  stall_cnt  out  SW  cycles a pending CPU request lost arbitration, saturates at all-ones
// BEHAVIOUR
//  - Reset (reset=0, async): CPU FSM=IDLE, mem_we=0, mem_addr/mem_wdata=0, vid_valid=0,
//    vid_data=0, cpu_ack=0, cpu_rdata=0, stall_cnt=0, return-tag pipe cleared (in-flight
//    reads discarded, no vid_valid/cpu_ack for them). n_wait follows cpu_req/cpu_ack.
//  - Arbitration at each edge: vid_req=1 wins unconditionally; else a CPU request in PEND issues.
//    Exactly one access issued per cycle; mem_we=0 whenever no CPU write issued.
//  - Issue at edge k drives mem_* during cycle k..k+1; BRAM samples at edge k+1; mem_rdata
//    captured at edge k+2. A 2-stage tag pipe {NONE,VID,CPU} routes returned data.
//  - Video latency fixed: vid_req sampled at edge k -> vid_valid=1, vid_data during cycle after
//    edge k+2. Never delayed by CPU traffic.
//  - CPU FSM: IDLE -(cpu_req=1)-> PEND; PEND -(no vid_req)-> ISSUE; PEND -(vid_req)-> PEND,
//    stall_cnt+1; ISSUE write -> ACK next edge; ISSUE read -> RD -> ACK (cpu_rdata loaded
//    with cpu_ack); ACK -(cpu_req=0)-> IDLE, cpu_ack drops same edge.
//  - IDLE with cpu_req=1 and vid_req=0 at the same edge: enters PEND, issues next edge
//    (min write latency 2 edges, read 3 edges from request sample to cpu_ack).
//  - Contract: vid_req never high on two consecutive edges (video fetches 1 in 16 cycles);
//    guarantees CPU issue within 2 edges of PEND. Violation flagged by simulation assertion.
//  - Write at edge k then video read of same address at edge k+1 returns new data.
//  - cpu_req dropped before ack (illegal): FSM completes access, ACK exits on next edge.
//  - stall_cnt: stall_clr has priority over increment; holds at 2^SW-1.
//  - Reset mid-access: write issued but not yet clocked by BRAM may be lost; no partial ack.
// TESTING
//  1. Video only: vid_req @edge 10 addr 0x0000, RAM[0]=0xA5 -> vid_valid=1, vid_data=0xA5 after edge 12.
//  2. CPU write 0x1800<=0x3C, no video -> n_wait low 2 cycles, cpu_ack, then video read of 0x1800 = 0x3C.
//  3. cpu_req read and vid_req same edge -> video issued first, stall_cnt=1, CPU rdata correct,
//     vid_valid timing unchanged vs test 1.
//  4. Video fetch every 16 cycles + CPU random R/W back-to-back 1000 ops -> scoreboard match,
//     zero video latency deviation, no CPU op waits >4 edges for issue.
//  5. Reset asserted during CPU read in RD -> no cpu_ack/vid_valid, all outputs reset values,
//     n_wait=1 once cpu_req low; stall_cnt=0.
//  6. Force 70000 stall cycles -> stall_cnt=0xFFFF holds; stall_clr pulse -> 0.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port screen BRAM between video scan-out and the Z80.
//
// Video fetches always win arbitration and see a fixed three-edge latency from vid_req to
// vid_valid. CPU accesses are held in a small FSM and issued on the first free edge. While
// a CPU request waits, n_wait stalls the Z80. stall_cnt counts how many edges a waiting
// CPU request lost to video.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   vid_req/vid_addr      one-cycle video fetch strobe and address
//   vid_data/vid_valid    fetched byte and its one-cycle valid pulse
//   cpu_req/cpu_we/...    4-phase CPU request (address, write data, direction)
//   cpu_rdata/cpu_ack     read data and level acknowledge
//   n_wait                Z80 WAIT, low while a request is outstanding and unacknowledged
//   mem_*                 registered BRAM command; mem_rdata arrives one cycle later
//   stall_clr/stall_cnt   synchronous clear and saturating contention counter
module vram_arbiter #(
   parameter int unsigned AW = 13,
   parameter int unsigned DW = 8,
   parameter int unsigned SW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic [DW-1:0] vid_data,
   output logic          vid_valid,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   output logic          n_wait,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          stall_clr,
   output logic [SW-1:0] stall_cnt
);

   typedef enum logic [2:0] {StIdle, StPend, StIssue, StRd, StAck} cpu_state_e;
   typedef enum logic [1:0] {TagNone, TagVid, TagCpu} tag_e;

   cpu_state_e state_q;
   tag_e       tag0_q;    // owner of the access issued at the last edge
   tag_e       tag1_q;    // owner of the data now on mem_rdata
   logic       op_we_q;   // direction of the issued CPU access, kept in case cpu_req drops
   logic       cpu_issue;
   logic       stall_inc;

   assign n_wait = ~(cpu_req & ~cpu_ack);

   always_comb begin
      cpu_issue = (state_q == StPend) && !vid_req;
      // A request sampled in IDLE on the same edge as a video fetch has also lost that edge.
      stall_inc = vid_req && ((state_q == StPend) || ((state_q == StIdle) && cpu_req));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         tag0_q    <= TagNone;
         tag1_q    <= TagNone;
         op_we_q   <= 1'b0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         vid_data  <= '0;
         vid_valid <= 1'b0;
         cpu_rdata <= '0;
         cpu_ack   <= 1'b0;
         stall_cnt <= '0;
      end else begin
         // Issue: exactly one access per edge, video first.
         mem_we <= 1'b0;
         if (vid_req) begin
            mem_addr <= vid_addr;
            tag0_q   <= TagVid;
         end else if (cpu_issue) begin
            mem_addr  <= cpu_addr;
            mem_we    <= cpu_we;
            mem_wdata <= cpu_wdata;
            op_we_q   <= cpu_we;
            tag0_q    <= cpu_we ? TagNone : TagCpu;
         end else begin
            tag0_q <= TagNone;
         end

         // Return path: tag1 marks the cycle in which mem_rdata holds the issued data.
         tag1_q    <= tag0_q;
         vid_valid <= (tag1_q == TagVid);
         if (tag1_q == TagVid) begin
            vid_data <= mem_rdata;
         end

         if (stall_clr) begin
            stall_cnt <= '0;
         end else if (stall_inc && (stall_cnt != {SW{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
         end

         unique case (state_q)
            StIdle: begin
               if (cpu_req) state_q <= StPend;
            end
            StPend: begin
               if (!vid_req) state_q <= StIssue;
            end
            StIssue: begin
               if (op_we_q) begin
                  state_q <= StAck;
                  cpu_ack <= 1'b1;
               end else begin
                  state_q <= StRd;
               end
            end
            StRd: begin
               state_q   <= StAck;
               cpu_ack   <= 1'b1;
               cpu_rdata <= mem_rdata;
            end
            StAck: begin
               if (!cpu_req) begin
                  state_q <= StIdle;
                  cpu_ack <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Video must leave a gap of at least one edge, otherwise a CPU request can starve.
   assert property (@(posedge clk) disable iff (!reset) vid_req |=> !vid_req);

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and randomised checks of vram_arbiter against a
// transaction-level model (shadow memory, fetch queue, per-request latency rules).
module tb_vram_arbiter;

   localparam int AW = 13;
   localparam int DW = 8;
   localparam int SW = 8;
   localparam int SMAX = (1 << SW) - 1;

   logic          clk;
   logic          reset;
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic [DW-1:0] vid_data;
   logic          vid_valid;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack;
   logic          n_wait;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          stall_clr;
   logic [SW-1:0] stall_cnt;

   vram_arbiter #(.AW(AW), .DW(DW), .SW(SW)) dut (
      .clk       (clk),
      .reset     (reset),
      .vid_req   (vid_req),
      .vid_addr  (vid_addr),
      .vid_data  (vid_data),
      .vid_valid (vid_valid),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .n_wait    (n_wait),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .stall_clr (stall_clr),
      .stall_cnt (stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] pat(input int i);
      return 8'(i * 37) ^ 8'hA5;
   endfunction

   // Synchronous screen BRAM, one-cycle read latency.
   logic [7:0] ram [0:8191];
   logic       ram_init;
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 8192; i++) ram[i] <= pat(i);
      end else begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end
   end

   // Reference model state
   logic [7:0]  shadow [0:8191];
   int          cyc;
   bit          active, acked, op_we;
   int          r;
   logic [12:0] op_addr;
   logic [7:0]  op_wdata;
   int          exp_stall;
   bit          vid_hist [64];
   int          vq_edge [$];
   logic [12:0] vq_addr [$];
   logic [7:0]  vq_data [$];
   int          vectors, miscompares;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cpu_start(input bit we, input logic [12:0] a, input logic [7:0] d);
      cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
      active = 1; acked = 0; op_we = we; op_addr = a; op_wdata = d; r = cyc + 1;
   endtask

   task automatic vid_start(input logic [12:0] a);
      vid_req = 1'b1; vid_addr = a;
      vq_edge.push_back(cyc + 1); vq_addr.push_back(a); vq_data.push_back(8'h00);
   endtask

   // One clock edge followed by all model checks for that edge.
   task automatic step();
      bit dv, dc, dr;
      int lat, exp_lat;
      dv = vid_req; dc = stall_clr; dr = cpu_req;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      vid_req = 1'b0; stall_clr = 1'b0;
      vid_hist[cyc % 64] = dv && reset;
      if (!reset) begin
         vq_edge.delete(); vq_addr.delete(); vq_data.delete();
         active = 0; exp_stall = 0; cpu_req = 1'b0;
      end else begin
         if (dc) exp_stall = 0;
         else if (dv && active && (cyc == r || cyc == r + 1) && exp_stall != SMAX) exp_stall++;
      end
      chk("stall_cnt", stall_cnt, exp_stall);

      if (active && acked && !dr) begin
         chk("ack_release", cpu_ack, 0);
         active = 0;
      end
      if (active && !acked) begin
         if (cpu_ack) begin
            lat = cyc - r;
            exp_lat = (op_we ? 2 : 3) + (vid_hist[(r + 1) % 64] ? 1 : 0);
            chk("cpu_latency", lat, exp_lat);
            if (op_we) shadow[op_addr] = op_wdata;
            else chk("cpu_rdata", cpu_rdata, shadow[op_addr]);
            acked = 1;
         end else if (cyc - r > 6) begin
            chk("cpu_ack_timeout", cpu_ack, 1);
            active = 0; cpu_req = 1'b0;
         end
      end
      if (!active) chk("cpu_ack_idle", cpu_ack, 0);

      // A fetch sampled at edge k sees every write acknowledged by edge k+1.
      for (int i = 0; i < vq_edge.size(); i++)
         if (vq_edge[i] == cyc - 1) vq_data[i] = shadow[vq_addr[i]];
      if (vq_edge.size() > 0 && vq_edge[0] == cyc - 2) begin
         chk("vid_valid", vid_valid, 1);
         chk("vid_data", vid_data, vq_data[0]);
         void'(vq_edge.pop_front()); void'(vq_addr.pop_front()); void'(vq_data.pop_front());
      end else begin
         chk("vid_valid_idle", vid_valid, 0);
      end

      if (active && acked && cpu_req) cpu_req = 1'b0;
   endtask

   task automatic run_until_idle();
      for (int i = 0; i < 12 && active; i++) step();
   endtask

   initial begin
      int gap, next_vid, ops;
      vectors = 0; miscompares = 0; cyc = 0; active = 0; acked = 0; exp_stall = 0;
      reset = 1'b0; ram_init = 1'b1;
      vid_req = 1'b0; vid_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0;
      cpu_addr = '0; cpu_wdata = '0; stall_clr = 1'b0;
      for (int i = 0; i < 8192; i++) shadow[i] = pat(i);
      for (int i = 0; i < 64; i++) vid_hist[i] = 0;

      // Reset state
      step();
      ram_init = 1'b0;
      step();
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_n_wait", n_wait, 1);
      reset = 1'b1;

      // Video only: fetch at edge 10 of address 0
      while (cyc < 9) step();
      vid_start(13'h0000);
      step(); step(); step();
      chk("t1_vid_valid", vid_valid, 1);
      chk("t1_vid_data", vid_data, 8'hA5);

      // CPU write, no video, then video readback
      step();
      cpu_start(1'b1, 13'h1800, 8'h3C);
      #1 chk("t2_n_wait_req", n_wait, 0);
      step();
      chk("t2_n_wait_pend", n_wait, 0);
      step();
      chk("t2_n_wait_issue", n_wait, 0);
      chk("t2_mem_we", mem_we, 1);
      chk("t2_mem_addr", mem_addr, 13'h1800);
      step();
      chk("t2_cpu_ack", cpu_ack, 1);
      chk("t2_n_wait_ack", n_wait, 1);
      vid_start(13'h1800);
      step(); step(); step();
      chk("t2_readback", vid_data, 8'h3C);

      // CPU read and video on the same edge
      step();
      cpu_start(1'b0, 13'h1800, 8'h00);
      vid_start(13'h0000);
      run_until_idle();
      chk("t3_stall", stall_cnt, 1);
      chk("t3_rdata", cpu_rdata, 8'h3C);

      // Randomised mixed traffic
      gap = 0; ops = 0; next_vid = cyc + 3;
      while ((ops < 1000 || active) && cyc < 30000) begin
         if (!active && ops < 1000) begin
            if (gap == 0) begin
               cpu_start(1'($urandom_range(0, 1)), 13'h1800 + 13'($urandom_range(0, 31)),
                         8'($urandom));
               ops++;
               gap = $urandom_range(0, 2);
            end else begin
               gap--;
            end
         end
         if (cyc + 1 == next_vid) begin
            vid_start(13'h1800 + 13'($urandom_range(0, 31)));
            next_vid = cyc + 1 + $urandom_range(2, 17);
         end
         if ($urandom_range(0, 99) == 0) stall_clr = 1'b1;
         step();
      end
      step(); step(); step();

      // Reset while a CPU read sits in RD, with a video fetch in flight
      cpu_start(1'b0, 13'h1805, 8'h00);
      step(); step();
      vid_start(13'h0002);
      step();
      reset = 1'b0; cpu_req = 1'b0;
      #1;
      chk("t5_cpu_ack", cpu_ack, 0);
      chk("t5_vid_valid", vid_valid, 0);
      chk("t5_mem_we", mem_we, 0);
      chk("t5_mem_addr", mem_addr, 0);
      chk("t5_mem_wdata", mem_wdata, 0);
      chk("t5_cpu_rdata", cpu_rdata, 0);
      chk("t5_vid_data", vid_data, 0);
      chk("t5_stall", stall_cnt, 0);
      chk("t5_n_wait", n_wait, 1);
      step(); step();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) step();

      // Saturation of the contention counter, then clear
      for (int i = 0; i < SMAX + 20; i++) begin
         cpu_start(1'b1, 13'h1810, 8'(i));
         vid_start(13'h0001);
         run_until_idle();
      end
      chk("t6_saturated", stall_cnt, SMAX);
      stall_clr = 1'b1;
      step();
      chk("t6_cleared", stall_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
